xoodyak_arbiter: RTL

//  Two-requester round-robin scheduler for one shared XOODYAK hash core.

---
 rtl/xoodyak_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/xoodyak_arbiter.sv
// Two-requester round-robin front end for a single shared XOODYAK hash core.
// Grants one job at a time, pulses core_start with the job length, streams the
// granted requester's message bytes into the core (paced by core_busy) and
// routes the returned digest bytes back to the same requester before done.
// Optional feature: define XDK_ARB_WATCHDOG_EN to abort a job whose digest
// stalls for WDOG_CYCLES cycles (err pulse, no done).
module xoodyak_arbiter #(
  parameter int LEN_W      = 12,
  parameter int HASH_BYTES = 32
`ifdef XDK_ARB_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       byte0,
  input  logic [7:0]       byte1,
  output logic             rd0,
  output logic             rd1,
  output logic [7:0]       hash_o,
  output logic             hval0,
  output logic             hval1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             core_start,
  output logic [7:0]       core_msg,
  output logic [LEN_W-1:0] core_msg_len,
  input  logic             core_busy,
  input  logic [7:0]       core_hash,
  input  logic             core_valid
);

  localparam int HC_W = $clog2(HASH_BYTES + 1);
`ifdef XDK_ARB_WATCHDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_HASH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;          // 0 = requester 0, 1 = requester 1
  logic              last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;    // never exceeds len, so no wrap
  logic [HC_W-1:0]   hash_cnt_q, hash_cnt_d;
  logic              rd_g;
  logic              hval_g;
`ifdef XDK_ARB_WATCHDOG_EN
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;
`endif

  // Next-state logic: arbitration, byte pacing, digest counting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    hash_cnt_d   = hash_cnt_q;
    rd_g         = 1'b0;
    hval_g       = 1'b0;
`ifdef XDK_ARB_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Prefer the requester that was not served last; fall back to the other.
          if (last_grant_q) begin
            grant_d = req0 ? 1'b0 : 1'b1;
          end else begin
            grant_d = req1 ? 1'b1 : 1'b0;
          end
          len_d   = grant_d ? len1 : len0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        byte_cnt_d = {LEN_W{1'b0}};
        hash_cnt_d = {HC_W{1'b0}};
`ifdef XDK_ARB_WATCHDOG_EN
        wd_cnt_d   = {WD_W{1'b0}};
`endif
        state_d    = (len_q == {LEN_W{1'b0}}) ? S_HASH : S_FEED;
      end
      S_FEED: begin
        rd_g = !core_busy;
        if (rd_g) begin
          byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if (byte_cnt_q == len_q - LEN_W'(1)) begin
            state_d = S_HASH;
          end else begin
            state_d = S_FEED;
          end
        end else begin
          state_d = S_FEED;
        end
      end
      S_HASH: begin
        hval_g = core_valid;
        if (core_valid) begin
          hash_cnt_d = hash_cnt_q + HC_W'(1);
`ifdef XDK_ARB_WATCHDOG_EN
          wd_cnt_d   = {WD_W{1'b0}};
`endif
          if (hash_cnt_q == HC_W'(HASH_BYTES - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HASH;
          end
        end else begin
`ifdef XDK_ARB_WATCHDOG_EN
          if (wd_cnt_q == WD_W'(WDOG_CYCLES - 1)) begin
            err_d        = 1'b1;
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
            state_d  = S_HASH;
          end
`else
          state_d = S_HASH;
`endif
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; a reset drops any job.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= {LEN_W{1'b0}};
      byte_cnt_q   <= {LEN_W{1'b0}};
      hash_cnt_q   <= {HC_W{1'b0}};
`ifdef XDK_ARB_WATCHDOG_EN
      wd_cnt_q     <= {WD_W{1'b0}};
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      hash_cnt_q   <= hash_cnt_d;
`ifdef XDK_ARB_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign rd0          = rd_g & ~grant_q;
  assign rd1          = rd_g & grant_q;
  assign hval0        = hval_g & ~grant_q;
  assign hval1        = hval_g & grant_q;
  assign done0        = (state_q == S_DONE) & ~grant_q;
  assign done1        = (state_q == S_DONE) & grant_q;
  assign core_start   = (state_q == S_START);
  assign core_msg_len = len_q;
  assign core_msg     = (state_q == S_FEED) ? (grant_q ? byte1 : byte0) : 8'd0;
  assign hash_o       = core_hash;
`ifdef XDK_ARB_WATCHDOG_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule
